// File: rtl/frame_crc_check.sv
// Per-frame CRC-32 checker for configuration readback. It compares each frame against a
// golden ROM, counts upsets and declares a SEFI on too many errors or a stalled stream.
module frame_crc_check #(
  parameter int WORDS_PER_FRAME = 41,
  parameter int NUM_FRAMES      = 16384,
  parameter int FRAME_AW        = 14,
  parameter int SEFI_THRESH     = 4,
  parameter int TIMEOUT_CYC     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scrub_start,
  input  logic                rb_valid,
  output logic                rb_ready,
  input  logic [31:0]         rb_data,
  output logic [FRAME_AW-1:0] gold_addr,
  input  logic [31:0]         gold_crc,
  output logic                frame_err,
  output logic [FRAME_AW-1:0] err_frame,
  output logic [7:0]          err_count,
  output logic                sefi_detected,
  output logic                scrub_done,
  output logic                busy
);

  localparam int WCW = $clog2(WORDS_PER_FRAME + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0]      LAST_W   = WCW'(WORDS_PER_FRAME - 1);
  localparam logic [TCW-1:0]      TO_LAST  = TCW'(TIMEOUT_CYC - 1);
  localparam logic [FRAME_AW-1:0] LAST_F   = FRAME_AW'(NUM_FRAMES - 1);
  localparam logic [7:0]          SEFI_T   = 8'(SEFI_THRESH);
  localparam logic [31:0]         CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]         POLY     = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_LOOKUP, S_COMPARE, S_DONE, S_ABORT
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        crc;
  logic [WCW-1:0]     word_cnt;
  logic [TCW-1:0]     timeout_cnt;
  logic [FRAME_AW-1:0] frame_idx;
  logic               handshake;
  logic               mismatch;
  logic [7:0]         err_post;

  // Whole 32-bit word folded in one cycle, MSB first, non-reflected.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ POLY) : {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign rb_ready      = (state == S_RUN);
  assign busy          = (state != S_IDLE);
  assign handshake     = rb_valid & rb_ready;
  assign mismatch      = (crc != gold_crc);
  assign frame_err     = (state == S_COMPARE) && mismatch;
  assign scrub_done    = (state == S_DONE);
  assign sefi_detected = (state == S_ABORT);
  assign gold_addr     = frame_idx;
  assign err_post      = !mismatch ? err_count :
                         (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (scrub_start) state_nxt = S_RUN;
      S_RUN: begin
        if (handshake && word_cnt == LAST_W)         state_nxt = S_LOOKUP;
        else if (!handshake && timeout_cnt == TO_LAST) state_nxt = S_ABORT;
      end
      S_LOOKUP:  state_nxt = S_COMPARE;
      S_COMPARE: begin
        if (err_post >= SEFI_T)       state_nxt = S_ABORT;
        else if (frame_idx == LAST_F) state_nxt = S_DONE;
        else                          state_nxt = S_RUN;
      end
      S_DONE:    state_nxt = S_IDLE;
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      crc         <= CRC_INIT;
      word_cnt    <= '0;
      timeout_cnt <= '0;
      frame_idx   <= '0;
      err_frame   <= '0;
      err_count   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: if (scrub_start) begin
          crc         <= CRC_INIT;
          word_cnt    <= '0;
          timeout_cnt <= '0;
          frame_idx   <= '0;
          err_frame   <= '0;
          err_count   <= '0;
        end
        S_RUN: begin
          if (handshake) begin
            crc         <= crc_next(crc, rb_data);
            word_cnt    <= word_cnt + 1'b1;
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        S_COMPARE: begin
          if (mismatch) err_frame <= frame_idx;
          err_count   <= err_post;
          crc         <= CRC_INIT;
          word_cnt    <= '0;
          timeout_cnt <= '0;
          if (state_nxt == S_RUN) frame_idx <= frame_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_crc_check.sv
// Self-checking bench for frame_crc_check: random readback streams, a byte-table CRC model,
// and a synchronous golden ROM built from that model.
module tb_frame_crc_check;

  localparam int W  = 41;
  localparam int NF = 4;
  localparam int FAW = 2;
  localparam int TH = 4;
  localparam int TO = 16;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           scrub_start = 1'b0;
  logic           rb_valid = 1'b0;
  logic           rb_ready;
  logic [31:0]    rb_data = '0;
  logic [FAW-1:0] gold_addr;
  logic [31:0]    gold_crc = '0;
  logic           frame_err;
  logic [FAW-1:0] err_frame;
  logic [7:0]     err_count;
  logic           sefi_detected;
  logic           scrub_done;
  logic           busy;

  frame_crc_check #(
    .WORDS_PER_FRAME(W), .NUM_FRAMES(NF), .FRAME_AW(FAW),
    .SEFI_THRESH(TH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .scrub_start(scrub_start),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data),
    .gold_addr(gold_addr), .gold_crc(gold_crc),
    .frame_err(frame_err), .err_frame(err_frame), .err_count(err_count),
    .sefi_detected(sefi_detected), .scrub_done(scrub_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] stream [NF*W];
  logic [31:0] gold_tab [NF];
  logic [31:0] ctab [256];

  always @(posedge clk) gold_crc <= gold_tab[gold_addr];

  int checks = 0;
  int failures = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0, hs_cnt = 0, ferr_cnt = 0, sefi_cnt = 0, done_cnt = 0;
  int rdylow_cnt = 0, overlap_cnt = 0;
  int last_hs_cyc = 0, ferr_cyc = 0, sefi_cyc = 0;
  logic [FAW-1:0] ferr_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (rb_valid && rb_ready) begin hs_cnt++; last_hs_cyc = cyc; end
    if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; ferr_addr = gold_addr; end
    if (sefi_detected) begin sefi_cnt++; sefi_cyc = cyc; end
    if (scrub_done) done_cnt++;
    if (busy && !rb_ready && !scrub_done) rdylow_cnt++;
    if (int'(frame_err) + int'(sefi_detected) + int'(scrub_done) > 1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: byte-at-a-time table method over big-endian word bytes.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    return {c[23:0], 8'h00} ^ ctab[c[31:24] ^ b];
  endfunction

  function automatic logic [31:0] model_frame(input int f);
    logic [31:0] c = 32'hFFFF_FFFF;
    logic [31:0] w;
    for (int i = 0; i < W; i++) begin
      w = stream[f*W + i];
      for (int k = 3; k >= 0; k--) c = crc_byte(c, w[8*k +: 8]);
    end
    return c;
  endfunction

  function automatic int exp_errs(input int frames);
    int n = 0;
    for (int f = 0; f < frames; f++) if (model_frame(f) != gold_tab[f]) n++;
    return n;
  endfunction

  task automatic gen_stream();
    for (int i = 0; i < NF*W; i++) stream[i] = $urandom;
    for (int f = 0; f < NF; f++) gold_tab[f] = model_frame(f);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_pass();
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
  endtask

  // Offers stream words with optional random idle gaps; pulse_at re-raises scrub_start.
  task automatic feed(input int n, input int gap_max, input int pulse_at, output bit ok);
    int idx = 0;
    int guard = 0;
    bit take;
    ok = 1'b1;
    while (idx < n) begin
      if (guard > 4000) begin ok = 1'b0; break; end
      if (gap_max > 0 && $urandom_range(0, 2) == 0) begin
        rb_valid = 1'b0;
        scrub_start = 1'b0;
        repeat ($urandom_range(1, gap_max)) begin tick(); guard++; end
      end
      rb_valid = 1'b1;
      rb_data = stream[idx];
      scrub_start = (idx == pulse_at);
      @(negedge clk);
      take = rb_ready;
      tick();
      guard++;
      if (take) idx++;
    end
    rb_valid = 1'b0;
    rb_data = '0;
    scrub_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int d0 = done_cnt;
    int s0 = sefi_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0 || sefi_cnt != s0) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  logic [31:0] outs_all;
  assign outs_all = {15'd0, rb_ready, frame_err, sefi_detected, scrub_done, busy,
                     err_count, err_frame, gold_addr};

  initial begin
    bit ok;
    int h0, f0, s0, d0, r0;
    int ne;
    logic [7:0] vec [9];
    logic [31:0] c;

    for (int b = 0; b < 256; b++) begin
      c = {b[7:0], 24'h0};
      repeat (8) c = c[31] ? ({c[30:0], 1'b0} ^ POLY) : {c[30:0], 1'b0};
      ctab[b] = c;
    end
    for (int f = 0; f < NF; f++) gold_tab[f] = '0;

    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_byte(c, vec[i]);
    check("model_check_value", c, 32'h0376_E6E7);

    repeat (3) tick();
    check("reset_outputs", outs_all, 32'h0);
    rst = 1'b0;
    tick();

    // Clean pass with a continuous stream.
    gen_stream();
    h0 = hs_cnt; f0 = ferr_cnt; s0 = sefi_cnt; d0 = done_cnt; r0 = rdylow_cnt;
    start_pass();
    check("busy_after_start", busy, 1'b1);
    feed(NF*W, 0, -1, ok);
    check("clean_feed_ok", ok, 1'b1);
    wait_end(20, ok);
    check("clean_end_seen", ok, 1'b1);
    check("clean_handshakes", hs_cnt - h0, NF*W);
    check("clean_frame_err", ferr_cnt - f0, exp_errs(NF));
    check("clean_done", done_cnt - d0, 1);
    check("clean_sefi", sefi_cnt - s0, 0);
    check("clean_ready_low", rdylow_cnt - r0, 2*NF);
    check("clean_err_count", err_count, 0);
    check("clean_busy_after", busy, 1'b0);

    // Single-bit flip in frame 2.
    gen_stream();
    stream[2*W + 20][7] = ~stream[2*W + 20][7];
    f0 = ferr_cnt; s0 = sefi_cnt; d0 = done_cnt;
    start_pass();
    feed(NF*W, 0, -1, ok);
    wait_end(20, ok);
    check("flip_end_seen", ok, 1'b1);
    check("flip_frame_err", ferr_cnt - f0, exp_errs(NF));
    check("flip_err_addr", ferr_addr, 2);
    check("flip_err_frame", err_frame, 2);
    check("flip_err_count", err_count, 1);
    check("flip_done", done_cnt - d0, 1);
    check("flip_sefi", sefi_cnt - s0, 0);

    // Every frame corrupted: the threshold is crossed on the last frame.
    gen_stream();
    for (int f = 0; f < NF; f++) stream[f*W + $urandom_range(0, W-1)] ^= 32'h1 << $urandom_range(0, 31);
    ne = exp_errs(NF);
    f0 = ferr_cnt; s0 = sefi_cnt; d0 = done_cnt;
    start_pass();
    feed(NF*W, 0, -1, ok);
    wait_end(20, ok);
    check("thresh_end_seen", ok, 1'b1);
    check("thresh_frame_err", ferr_cnt - f0, ne);
    check("thresh_sefi", sefi_cnt - s0, (ne >= TH) ? 1 : 0);
    check("thresh_sefi_after_err", sefi_cyc - ferr_cyc, 1);
    check("thresh_no_done", done_cnt - d0, 0);
    check("thresh_busy_after", busy, 1'b0);
    check("thresh_err_count", err_count, ne);
    check("thresh_err_frame", err_frame, NF-1);

    // Stalled readback after 10 words. The abort state is entered TO edges after the
    // edge that took the last word, so it is seen one sample later than that.
    gen_stream();
    s0 = sefi_cnt; d0 = done_cnt;
    start_pass();
    feed(10, 0, -1, ok);
    wait_end(TO + 40, ok);
    check("timeout_end_seen", ok, 1'b1);
    check("timeout_sefi", sefi_cnt - s0, 1);
    check("timeout_latency", sefi_cyc - last_hs_cyc, TO + 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_ready_after", rb_ready, 1'b0);
    check("timeout_err_count", err_count, 0);

    // Random gaps plus a scrub_start re-pulse mid-pass.
    gen_stream();
    h0 = hs_cnt; f0 = ferr_cnt; s0 = sefi_cnt; d0 = done_cnt;
    start_pass();
    feed(NF*W, 5, 60, ok);
    check("bp_feed_ok", ok, 1'b1);
    wait_end(20, ok);
    check("bp_end_seen", ok, 1'b1);
    check("bp_handshakes", hs_cnt - h0, NF*W);
    check("bp_frame_err", ferr_cnt - f0, exp_errs(NF));
    check("bp_done", done_cnt - d0, 1);
    check("bp_sefi", sefi_cnt - s0, 0);

    // Reset at frame 1 word 5, then a fresh full pass.
    f0 = ferr_cnt; s0 = sefi_cnt; d0 = done_cnt;
    start_pass();
    feed(W + 5, 3, -1, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs", outs_all, 32'h0);
    repeat (6) tick();
    check("midrst_no_pulses", (ferr_cnt - f0) + (sefi_cnt - s0) + (done_cnt - d0), 0);
    check("midrst_idle", busy, 1'b0);
    f0 = ferr_cnt; d0 = done_cnt;
    start_pass();
    feed(NF*W, 4, -1, ok);
    wait_end(20, ok);
    check("rerun_end_seen", ok, 1'b1);
    check("rerun_done", done_cnt - d0, 1);
    check("rerun_frame_err", ferr_cnt - f0, exp_errs(NF));

    // All-zero frames: frame 0 golden off by one, frame 1 golden exact.
    for (int i = 0; i < NF*W; i++) stream[i] = '0;
    for (int f = 0; f < NF; f++) gold_tab[f] = model_frame(f);
    gold_tab[0] = gold_tab[0] + 32'd1;
    f0 = ferr_cnt;
    start_pass();
    feed(2*W, 0, -1, ok);
    repeat (4) tick();
    check("zero_frame_err", ferr_cnt - f0, exp_errs(2));
    check("zero_err_addr", ferr_addr, 0);
    check("zero_err_count", err_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    check("pulse_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
